// File: rtl/fft_bfly_scheduler.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT built around one combinational butterfly.
// Each butterfly takes two cycles: RD (issue RAM/ROM reads) then EX (write MAC results back).
module fft_bfly_scheduler #(
  parameter int LOG2N  = 5,
  parameter int ADDR_W = LOG2N,
  parameter int TW_W   = LOG2N - 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr0,
  output logic [ADDR_W-1:0] o_rd_addr1,
  output logic [TW_W-1:0]   o_tw_addr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr0,
  output logic [ADDR_W-1:0] o_wr_addr1,
  output logic [2:0]        o_stage
);

  localparam int S_W = $clog2(LOG2N + 1);
  localparam int K_W = ADDR_W - 1;
  localparam logic [S_W-1:0] S_LAST = S_W'(LOG2N - 1);
  localparam logic [K_W-1:0] K_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_EX,
    ST_DONE
  } state_t;

  state_t            r_state, w_state_next;
  logic [S_W-1:0]    r_s, w_s_next;
  logic [K_W-1:0]    r_k, w_k_next;

  logic [ADDR_W-1:0] w_k_ext, w_mask, w_a, w_b;
  logic [TW_W-1:0]   w_tw;

  logic              r_busy, r_done, r_rd_en, r_wr_en;
  logic [ADDR_W-1:0] r_rd_addr0, r_rd_addr1, r_wr_addr0, r_wr_addr1;
  logic [TW_W-1:0]   r_tw_addr;
  logic [S_W-1:0]    r_stage;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_k     <= w_k_next;
    end
  end

  // Counters advance only on leaving EX; the final butterfly clears them for the next run.
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_k_next     = r_k;
    unique case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_RD;
      ST_RD:   w_state_next = ST_EX;
      ST_EX: begin
        if (r_k != K_LAST) begin
          w_k_next     = r_k + K_W'(1);
          w_state_next = ST_RD;
        end else if (r_s != S_LAST) begin
          w_k_next     = '0;
          w_s_next     = r_s + S_W'(1);
          w_state_next = ST_RD;
        end else begin
          w_k_next     = '0;
          w_s_next     = '0;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Butterfly pair for the upcoming (s,k): insert a zero at bit s of k to get the top index.
  always_comb begin
    w_k_ext = {1'b0, w_k_next};
    w_mask  = (ADDR_W'(1) << w_s_next) - ADDR_W'(1);
    w_a     = ((w_k_ext >> w_s_next) << (w_s_next + S_W'(1))) | (w_k_ext & w_mask);
    w_b     = w_a | (w_mask + ADDR_W'(1));
    w_tw    = TW_W'((w_k_ext & w_mask) << (S_LAST - w_s_next));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_addr0 <= '0;
      r_rd_addr1 <= '0;
      r_wr_addr0 <= '0;
      r_wr_addr1 <= '0;
      r_tw_addr  <= '0;
      r_stage    <= '0;
    end else begin
      r_busy  <= (w_state_next == ST_RD) || (w_state_next == ST_EX);
      r_done  <= (w_state_next == ST_DONE);
      r_rd_en <= (w_state_next == ST_RD);
      r_wr_en <= (w_state_next == ST_EX);
      if (w_state_next == ST_RD) begin
        r_rd_addr0 <= w_a;
        r_rd_addr1 <= w_b;
        r_tw_addr  <= w_tw;
        r_stage    <= w_s_next;
      end
      // Write-back targets the pair that was just read; tw_addr stays put through EX.
      if (w_state_next == ST_EX) begin
        r_wr_addr0 <= r_rd_addr0;
        r_wr_addr1 <= r_rd_addr1;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rd_en    = r_rd_en;
  assign o_wr_en    = r_wr_en;
  assign o_rd_addr0 = r_rd_addr0;
  assign o_rd_addr1 = r_rd_addr1;
  assign o_wr_addr0 = r_wr_addr0;
  assign o_wr_addr1 = r_wr_addr1;
  assign o_tw_addr  = r_tw_addr;
  assign o_stage    = 3'(r_stage);

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Directed bench for fft_bfly_scheduler (32-point default) with a small RAM/ROM/MAC model
// used for the end-to-end impulse run.
module tb_fft_bfly_scheduler;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       o_busy, o_done, o_rd_en, o_wr_en;
  logic [4:0] o_rd_addr0, o_rd_addr1, o_wr_addr0, o_wr_addr1;
  logic [3:0] o_tw_addr;
  logic [2:0] o_stage;

  int checks   = 0;
  int failures = 0;

  fft_bfly_scheduler dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rd_en    (o_rd_en),
    .o_rd_addr0 (o_rd_addr0),
    .o_rd_addr1 (o_rd_addr1),
    .o_tw_addr  (o_tw_addr),
    .o_wr_en    (o_wr_en),
    .o_wr_addr0 (o_wr_addr0),
    .o_wr_addr1 (o_wr_addr1),
    .o_stage    (o_stage)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- RAM / twiddle ROM / MAC model (FRAC=7, packed {re,im}) ----------------
  logic [31:0] ram [0:31];
  logic [31:0] rom [0:15];
  logic [31:0] q0, q1, twq;
  logic [31:0] mac_out0, mac_out1;
  logic        pre_clr;

  initial begin
    for (int j = 0; j < 16; j++) begin
      rom[j] = {16'($rtoi($cos(2.0 * 3.14159265358979 * j / 32.0) * 128.0)),
                16'(-$rtoi($sin(2.0 * 3.14159265358979 * j / 32.0) * 128.0))};
    end
  end

  always @(posedge i_clk) begin
    if (pre_clr) begin
      for (int j = 0; j < 32; j++) ram[j] <= 32'h0;
      ram[0] <= 32'h0080_0000;
    end else begin
      if (o_rd_en) begin
        q0 <= ram[o_rd_addr0];
        q1 <= ram[o_rd_addr1];
      end
      twq <= rom[o_tw_addr];
      if (o_wr_en) begin
        ram[o_wr_addr0] <= mac_out0;
        ram[o_wr_addr1] <= mac_out1;
      end
    end
  end

  always_comb begin
    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    int p_re, p_im;
    a_re = q0[31:16];  a_im = q0[15:0];
    b_re = q1[31:16];  b_im = q1[15:0];
    w_re = twq[31:16]; w_im = twq[15:0];
    p_re = (int'(b_re) * int'(w_re) - int'(b_im) * int'(w_im)) >>> 7;
    p_im = (int'(b_re) * int'(w_im) + int'(b_im) * int'(w_re)) >>> 7;
    mac_out0 = {16'(int'(a_re) + p_re), 16'(int'(a_im) + p_im)};
    mac_out1 = {16'(int'(a_re) - p_re), 16'(int'(a_im) - p_im)};
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Presents start for one edge (edge T0); returns sampling cycle T0+1.
  task automatic start_run;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    pre_clr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({o_busy, o_done, o_rd_en, o_wr_en} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=0000", {o_busy, o_done, o_rd_en, o_wr_en});
    end
    checks++;
    if ({o_rd_addr0, o_rd_addr1, o_tw_addr, o_wr_addr0, o_wr_addr1, o_stage} !== '0) begin
      failures++;
      $display("FAIL reset_addrs got=%h want=0",
               {o_rd_addr0, o_rd_addr1, o_tw_addr, o_wr_addr0, o_wr_addr1, o_stage});
    end
    i_rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if ({o_busy, o_done, o_rd_en, o_wr_en} !== 4'b0) begin
        failures++;
        $display("FAIL idle_strobes cyc=%0d got=%b want=0000", n, {o_busy, o_done, o_rd_en, o_wr_en});
      end
      checks++;
      if ({o_rd_addr0, o_rd_addr1, o_tw_addr, o_wr_addr0, o_wr_addr1} !== '0) begin
        failures++;
        $display("FAIL idle_addrs cyc=%0d got=%h want=0", n,
                 {o_rd_addr0, o_rd_addr1, o_tw_addr, o_wr_addr0, o_wr_addr1});
      end
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_first_butterfly;
    start_run();
    checks++;
    if ({o_busy, o_rd_en, o_wr_en, o_rd_addr0, o_rd_addr1, o_tw_addr, o_stage} !==
        {1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL first_rd got busy=%b rd=%b wr=%b a=%0d b=%0d tw=%0d st=%0d want 1 1 0 0 1 0 0",
               o_busy, o_rd_en, o_wr_en, o_rd_addr0, o_rd_addr1, o_tw_addr, o_stage);
    end
    tick();
    checks++;
    if ({o_busy, o_rd_en, o_wr_en, o_wr_addr0, o_wr_addr1, o_tw_addr} !==
        {1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 4'd0}) begin
      failures++;
      $display("FAIL first_ex got busy=%b rd=%b wr=%b wa=%0d wb=%0d tw=%0d want 1 0 1 0 1 0",
               o_busy, o_rd_en, o_wr_en, o_wr_addr0, o_wr_addr1, o_tw_addr);
    end
    tick();
    checks++;
    if ({o_rd_en, o_wr_en, o_rd_addr0, o_rd_addr1} !== {1'b1, 1'b0, 5'd2, 5'd3}) begin
      failures++;
      $display("FAIL second_rd got rd=%b wr=%b a=%0d b=%0d want 1 0 2 3",
               o_rd_en, o_wr_en, o_rd_addr0, o_rd_addr1);
    end
    repeat (170) tick();
    $display("test_first_butterfly done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_addr_rule;
    start_run();
    repeat (74) tick();  // cycle T0+75: RD of stage 2, k=5
    checks++;
    if ({o_rd_en, o_rd_addr0, o_rd_addr1, o_tw_addr, o_stage} !== {1'b1, 5'd9, 5'd13, 4'd4, 3'd2}) begin
      failures++;
      $display("FAIL s2k5_rd got rd=%b a=%0d b=%0d tw=%0d st=%0d want 1 9 13 4 2",
               o_rd_en, o_rd_addr0, o_rd_addr1, o_tw_addr, o_stage);
    end
    tick();
    checks++;
    if ({o_wr_en, o_wr_addr0, o_wr_addr1, o_tw_addr} !== {1'b1, 5'd9, 5'd13, 4'd4}) begin
      failures++;
      $display("FAIL s2k5_ex got wr=%b wa=%0d wb=%0d tw=%0d want 1 9 13 4",
               o_wr_en, o_wr_addr0, o_wr_addr1, o_tw_addr);
    end
    repeat (59) tick();  // cycle T0+135: RD of stage 4, k=3
    checks++;
    if ({o_rd_en, o_rd_addr0, o_rd_addr1, o_tw_addr, o_stage} !== {1'b1, 5'd3, 5'd19, 4'd3, 3'd4}) begin
      failures++;
      $display("FAIL s4k3_rd got rd=%b a=%0d b=%0d tw=%0d st=%0d want 1 3 19 3 4",
               o_rd_en, o_rd_addr0, o_rd_addr1, o_tw_addr, o_stage);
    end
    repeat (40) tick();
    $display("test_addr_rule done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_full_run;
    bit   seen [0:4][0:31];
    int   rd_cnt = 0, wr_cnt = 0, uniq = 0;
    logic [4:0] pa = '0, pb = '0;
    logic [3:0] ptw = '0;
    bit   exp_rd, exp_wr, exp_busy, exp_done;
    for (int s = 0; s < 5; s++) for (int j = 0; j < 32; j++) seen[s][j] = 1'b0;
    start_run();
    for (int n = 1; n <= 165; n++) begin
      exp_rd   = (n <= 159) && (n % 2 == 1);
      exp_wr   = (n <= 160) && (n % 2 == 0);
      exp_busy = (n <= 160);
      exp_done = (n == 161);
      checks++;
      if ({o_rd_en, o_wr_en, o_busy, o_done} !== {exp_rd, exp_wr, exp_busy, exp_done}) begin
        failures++;
        $display("FAIL run_strobes cyc=%0d got rd/wr/busy/done=%b want=%b", n,
                 {o_rd_en, o_wr_en, o_busy, o_done}, {exp_rd, exp_wr, exp_busy, exp_done});
      end
      if (o_rd_en) begin
        int st;
        rd_cnt++;
        st = (n - 1) / 32;
        checks++;
        if (int'(o_stage) != st || int'(o_rd_addr1) != int'(o_rd_addr0) + (1 << st) ||
            o_rd_addr0[st] !== 1'b0 || seen[st][o_rd_addr0]) begin
          failures++;
          $display("FAIL run_pair cyc=%0d got st=%0d a=%0d b=%0d want st=%0d fresh pair span %0d",
                   n, o_stage, o_rd_addr0, o_rd_addr1, st, 1 << st);
        end else begin
          seen[st][o_rd_addr0] = 1'b1;
          uniq++;
        end
        pa = o_rd_addr0; pb = o_rd_addr1; ptw = o_tw_addr;
      end
      if (o_wr_en) begin
        wr_cnt++;
        checks++;
        if ({o_wr_addr0, o_wr_addr1, o_tw_addr} !== {pa, pb, ptw}) begin
          failures++;
          $display("FAIL run_wb cyc=%0d got wa=%0d wb=%0d tw=%0d want %0d %0d %0d",
                   n, o_wr_addr0, o_wr_addr1, o_tw_addr, pa, pb, ptw);
        end
      end
      tick();
    end
    checks++;
    if (rd_cnt != 80 || wr_cnt != 80 || uniq != 80) begin
      failures++;
      $display("FAIL run_counts got rd=%0d wr=%0d uniq=%0d want 80 80 80", rd_cnt, wr_cnt, uniq);
    end
    $display("test_full_run done rd=%0d wr=%0d checks=%0d failures=%0d", rd_cnt, wr_cnt, checks, failures);
  endtask

  task automatic test_ignored_start;
    int done_cnt = 0, rd_cnt = 0;
    start_run();
    for (int n = 1; n <= 300; n++) begin
      if (o_done) done_cnt++;
      if (o_rd_en) rd_cnt++;
      if (n == 161) begin
        checks++;
        if (o_done !== 1'b1) begin
          failures++;
          $display("FAIL ign_done_cycle got done=%b want 1", o_done);
        end
      end
      i_start = (n == 50) || (n == 161);
      tick();
    end
    i_start = 1'b0;
    checks++;
    if (done_cnt != 1 || rd_cnt != 80) begin
      failures++;
      $display("FAIL ign_no_rerun got done_cnt=%0d rd_cnt=%0d want 1 80", done_cnt, rd_cnt);
    end
    $display("test_ignored_start done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid_run;
    int rd_cnt = 0;
    start_run();
    repeat (37) tick();  // cycle T0+38: EX
    checks++;
    if (o_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_ex got wr=%b want 1", o_wr_en);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_wr_en, o_busy, o_rd_en, o_done} !== 4'b0) begin
      failures++;
      $display("FAIL mid_abort got wr/busy/rd/done=%b want 0000", {o_wr_en, o_busy, o_rd_en, o_done});
    end
    checks++;
    if ({o_rd_addr0, o_rd_addr1, o_tw_addr, o_wr_addr0, o_wr_addr1, o_stage} !== '0) begin
      failures++;
      $display("FAIL mid_abort_addrs got=%h want 0",
               {o_rd_addr0, o_rd_addr1, o_tw_addr, o_wr_addr0, o_wr_addr1, o_stage});
    end
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    start_run();
    checks++;
    if ({o_rd_en, o_rd_addr0, o_rd_addr1, o_tw_addr, o_stage} !== {1'b1, 5'd0, 5'd1, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL restart_rd got rd=%b a=%0d b=%0d tw=%0d st=%0d want 1 0 1 0 0",
               o_rd_en, o_rd_addr0, o_rd_addr1, o_tw_addr, o_stage);
    end
    for (int n = 1; n <= 165; n++) begin
      if (o_rd_en) rd_cnt++;
      if (n == 161) begin
        checks++;
        if ({o_done, o_busy} !== 2'b10) begin
          failures++;
          $display("FAIL restart_done got done/busy=%b want 10", {o_done, o_busy});
        end
      end
      tick();
    end
    checks++;
    if (rd_cnt != 80) begin
      failures++;
      $display("FAIL restart_count got rd=%0d want 80", rd_cnt);
    end
    $display("test_reset_mid_run done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_end_to_end;
    pre_clr = 1'b1;
    tick();
    pre_clr = 1'b0;
    start_run();
    repeat (170) tick();
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (ram[j] !== 32'h0080_0000) begin
        failures++;
        $display("FAIL e2e_bin%0d got=%h want=00800000", j, ram[j]);
      end
    end
    $display("test_end_to_end done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_first_butterfly();
    test_addr_rule();
    test_full_run();
    test_ignored_start();
    test_reset_mid_run();
    test_end_to_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
